// File: rtl/acc_store_buffer.sv
// Accumulator write-back store buffer: in-order FIFO of {addr, byte} drained over a
// req/ack port to data memory, with youngest-match forwarding to same-address loads.
module acc_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              store_en,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [7:0]        acc_out,
  output logic              store_stall,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  input  logic              mem_wr_ack,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              fwd_hit,
  output logic [7:0]        fwd_data,
  output logic              sb_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] addr_reg [DEPTH];
  logic [7:0]        data_reg [DEPTH];
  logic [PW-1:0]     wp_reg;
  logic [PW-1:0]     rp_reg;
  logic [PW:0]       count_reg;

  logic              push;
  logic              pop;
  logic [PW-1:0]     head_idx;
  logic [DEPTH-1:0]  match;

  assign store_stall = (count_reg == (PW+1)'(DEPTH));
  assign mem_wr_req  = (count_reg != '0);
  assign sb_empty    = (count_reg == '0);
  assign push        = store_en && !store_stall;
  assign pop         = mem_wr_req && mem_wr_ack;

  // When empty, keep showing the entry that was drained last instead of a stale slot.
  assign head_idx    = mem_wr_req ? rp_reg : (rp_reg - PW'(1));
  assign mem_wr_addr = addr_reg[head_idx];
  assign mem_wr_data = data_reg[head_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_reg[i] <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_reg[wp_reg] <= store_addr;
        data_reg[wp_reg] <= acc_out;
        wp_reg           <= wp_reg + PW'(1);
      end
      if (pop) begin
        rp_reg <= rp_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // match[k] refers to the k-th oldest pending entry, so higher k is younger.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    logic [PW-1:0] idx;
    assign idx       = rp_reg + PW'(gi);
    assign match[gi] = ((PW+1)'(gi) < count_reg) && (addr_reg[idx] == load_addr);
  end

  always_comb begin
    fwd_hit  = |match;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        fwd_data = data_reg[rp_reg + PW'(k)];
      end
    end
  end

endmodule

// File: tb/tb_acc_store_buffer.sv
// Directed self-checking bench for acc_store_buffer (DEPTH=4, ADDR_W=16).
`timescale 1ns/1ps
module tb_acc_store_buffer;

  logic        clock;
  logic        reset_n;
  logic        store_en;
  logic [15:0] store_addr;
  logic [7:0]  acc_out;
  logic        store_stall;
  logic        mem_wr_req;
  logic [15:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_ack;
  logic [15:0] load_addr;
  logic        fwd_hit;
  logic [7:0]  fwd_data;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;

  acc_store_buffer #(.DEPTH(4), .ADDR_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .store_en(store_en), .store_addr(store_addr),
    .acc_out(acc_out), .store_stall(store_stall), .mem_wr_req(mem_wr_req),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .load_addr(load_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .sb_empty(sb_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; store_en = 1'b0; store_addr = '0; acc_out = '0;
    mem_wr_ack = 1'b0; load_addr = '0;
    repeat (2) tick();
    checks++; if (store_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", store_stall); end
    checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_wr_req); end
    checks++; if (mem_wr_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0000", mem_wr_addr); end
    checks++; if (mem_wr_data !== 8'h0) begin errors++; $display("FAIL reset_data got=%h exp=00", mem_wr_data); end
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 8'h0) begin errors++; $display("FAIL reset_fwd got=%b/%h exp=0/00", fwd_hit, fwd_data); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", sb_empty); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_store();
    store_en = 1'b1; store_addr = 16'h0010; acc_out = 8'h2A;
    checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%b exp=0", mem_wr_req); end
    tick();
    store_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_wr_req !== 1'b1 || mem_wr_addr !== 16'h0010 || mem_wr_data !== 8'h2A) begin
        errors++; $display("FAIL single_hold%0d got=%b/%h/%h exp=1/0010/2a", i, mem_wr_req, mem_wr_addr, mem_wr_data);
      end
      if (i < 3) tick();
    end
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    $display("write addr=0010 data=2a");
    checks++; if (mem_wr_req !== 1'b0 || sb_empty !== 1'b1) begin errors++; $display("FAIL single_drain got=%b/%b exp=0/1", mem_wr_req, sb_empty); end
  endtask

  // Fill four entries with consecutive addresses, then drain with ack held high.
  task automatic fill_and_drain(input logic [15:0] base_addr, input logic [7:0] base_data, input string tag);
    for (int i = 0; i < 4; i++) begin
      store_en = 1'b1; store_addr = base_addr + 16'(i); acc_out = base_data + 8'(i);
      tick();
    end
    checks++; if (store_stall !== 1'b1) begin errors++; $display("FAIL %s_full got=%b exp=1", tag, store_stall); end
    acc_out = 8'h05; store_addr = 16'hFFFF;
    tick();
    store_en = 1'b0;
    checks++;
    if (store_stall !== 1'b1 || mem_wr_data !== base_data) begin
      errors++; $display("FAIL %s_refuse got=%b/%h exp=1/%h", tag, store_stall, mem_wr_data, base_data);
    end
    mem_wr_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_wr_req !== 1'b1 || mem_wr_addr !== base_addr + 16'(i) || mem_wr_data !== base_data + 8'(i)) begin
        errors++; $display("FAIL %s_order%0d got=%b/%h/%h exp=1/%h/%h", tag, i, mem_wr_req,
                           mem_wr_addr, mem_wr_data, base_addr + 16'(i), base_data + 8'(i));
      end
      $display("write addr=%h data=%h", mem_wr_addr, mem_wr_data);
      tick();
    end
    mem_wr_ack = 1'b0;
    checks++; if (mem_wr_req !== 1'b0 || sb_empty !== 1'b1) begin errors++; $display("FAIL %s_empty got=%b/%b exp=0/1", tag, mem_wr_req, sb_empty); end
  endtask

  task automatic test_full_and_wrap();
    fill_and_drain(16'h0000, 8'h01, "burst1");
    fill_and_drain(16'h0100, 8'hA1, "burst2");
  endtask

  task automatic test_full_simultaneous();
    for (int i = 0; i < 4; i++) begin
      store_en = 1'b1; store_addr = 16'h0300 + 16'(i); acc_out = 8'hB1 + 8'(i);
      tick();
    end
    checks++; if (store_stall !== 1'b1) begin errors++; $display("FAIL simul_full got=%b exp=1", store_stall); end
    store_addr = 16'h0200; acc_out = 8'hC5; mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    checks++;
    if (store_stall !== 1'b0 || mem_wr_data !== 8'hB2) begin
      errors++; $display("FAIL simul_pop got=%b/%h exp=0/b2", store_stall, mem_wr_data);
    end
    tick();
    store_en = 1'b0;
    checks++;
    if (store_stall !== 1'b1 || mem_wr_data !== 8'hB2) begin
      errors++; $display("FAIL simul_retry got=%b/%h exp=1/b2", store_stall, mem_wr_data);
    end
    mem_wr_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 3) ? 8'hB2 + 8'(i) : 8'hC5;
      checks++;
      if (mem_wr_req !== 1'b1 || mem_wr_data !== exp_d) begin
        errors++; $display("FAIL simul_order%0d got=%b/%h exp=1/%h", i, mem_wr_req, mem_wr_data, exp_d);
      end
      $display("write addr=%h data=%h", mem_wr_addr, mem_wr_data);
      tick();
    end
    mem_wr_ack = 1'b0;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL simul_empty got=%b exp=1", sb_empty); end
  endtask

  task automatic test_forwarding();
    store_en = 1'b1; store_addr = 16'h0040; acc_out = 8'h11; tick();
    acc_out = 8'h22; tick();
    store_addr = 16'h0041; acc_out = 8'h33; tick();
    store_en = 1'b0;
    load_addr = 16'h0040; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h22) begin errors++; $display("FAIL fwd_youngest got=%b/%h exp=1/22", fwd_hit, fwd_data); end
    load_addr = 16'h0041; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h33) begin errors++; $display("FAIL fwd_other got=%b/%h exp=1/33", fwd_hit, fwd_data); end
    load_addr = 16'h0050; #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 8'h00) begin errors++; $display("FAIL fwd_miss got=%b/%h exp=0/00", fwd_hit, fwd_data); end
    store_en = 1'b1; store_addr = 16'h0050; acc_out = 8'h44; #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_no_enq got=%b exp=0", fwd_hit); end
    tick();
    store_en = 1'b0; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h44) begin errors++; $display("FAIL fwd_after_enq got=%b/%h exp=1/44", fwd_hit, fwd_data); end
    // Head entry 0x11@0x0040 is being acked; 0x22 still wins as youngest.
    load_addr = 16'h0040; mem_wr_ack = 1'b1; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h22) begin errors++; $display("FAIL fwd_acking got=%b/%h exp=1/22", fwd_hit, fwd_data); end
    repeat (4) tick();
    mem_wr_ack = 1'b0; load_addr = '0;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL fwd_drain got=%b exp=1", sb_empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      store_en = 1'b1; store_addr = 16'h0500 + 16'(i); acc_out = 8'h70 + 8'(i);
      tick();
    end
    store_en = 1'b0;
    checks++; if (mem_wr_req !== 1'b1) begin errors++; $display("FAIL rstmid_pending got=%b exp=1", mem_wr_req); end
    reset_n = 1'b0; #1;
    checks++; if (mem_wr_req !== 1'b0 || sb_empty !== 1'b1) begin errors++; $display("FAIL rstmid_async got=%b/%b exp=0/1", mem_wr_req, sb_empty); end
    tick();
    reset_n = 1'b1;
    mem_wr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_wr_req !== 1'b0 || sb_empty !== 1'b1 || mem_wr_addr !== 16'h0) begin
        errors++; $display("FAIL rstmid_idle%0d got=%b/%b/%h exp=0/1/0000", i, mem_wr_req, sb_empty, mem_wr_addr);
      end
    end
    mem_wr_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_d;
    logic [15:0] exp_a;
    for (int i = 0; i < 10; i++) begin
      exp_d = 8'($urandom_range(0, 255));
      exp_a = 16'($urandom_range(0, 65535));
      store_en = 1'b1; store_addr = exp_a; acc_out = exp_d; mem_wr_ack = 1'b0;
      checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL b2b_count%0d got_empty=%b exp=1", i, sb_empty); end
      tick();
      store_en = 1'b0; mem_wr_ack = 1'b1;
      checks++;
      if (mem_wr_req !== 1'b1 || mem_wr_addr !== exp_a || mem_wr_data !== exp_d) begin
        errors++; $display("FAIL b2b_write%0d got=%b/%h/%h exp=1/%h/%h", i, mem_wr_req, mem_wr_addr, mem_wr_data, exp_a, exp_d);
      end
      $display("write addr=%h data=%h", mem_wr_addr, mem_wr_data);
      tick();
    end
    mem_wr_ack = 1'b0;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL b2b_end got=%b exp=1", sb_empty); end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full_and_wrap();
    test_full_simultaneous();
    test_forwarding();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
